alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Hardwired control unit that drives the Phase 1 bus datapath's control inputs.
- It replaces the hand-timed T0–T5 stimulus with a clocked state machine.
- It fetches each instruction (PC→MAR, memory→MDR→IR), decodes IR[31:27], and sequences R-format ALU instructions through Y, Z, HI and LO.
- It sits directly upstream of the bus block. Every control output feeds the same-named bus input.

Parameters:
- MEM_WAIT_MAX, 15, maximum T1 stall cycles before the memory timeout flag is raised (4-bit counter).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset (asserted when 0).
- run  in  1  level; 1 = keep issuing instructions, 0 = stop at the next instruction boundary.
- mem_rdy  in  1  memory data valid on Mdatain; sampled in T1.
- ir  in  32  IR contents from the datapath.
- PCout, MARin, IncPC, PCin, MDRRead, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes.
- Rout  out  16  one-hot register-out select, bit n drives RnOut.
- Rin  out  16  one-hot register-in enable, bit n drives RnIn.
- ALUControl  out  12  one-hot ALU operation.
- done  out  1  one-cycle pulse at the end of each instruction.
- illegal  out  1  sticky flag: unsupported opcode seen.
- mem_timeout  out  1  sticky flag: T1 stall exceeded MEM_WAIT_MAX.

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register plus ir; no output depends on run or mem_rdy.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Reset (clr=0, any time, mid-instruction included): state=IDLE, stall counter=0, illegal=0, mem_timeout=0. All strobes, Rout, Rin, ALUControl and done are 0.
- IDLE: go to T0 when run=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, MDRRead, MDRin.
  - Stay in T1 while mem_rdy=0; the counter increments each stall cycle.
  - When the counter reaches MEM_WAIT_MAX, set mem_timeout and go to IDLE.
  - When mem_rdy=1, go to T2 and clear the counter.
- T2: MDRout, IRin. Go to T3.
- IR fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- T3: Rout[rb]=1, Yin.
  - op unsupported: illegal=1, done=1, skip the instruction (next state T0 if run=1, else IDLE). No register is written.
- T4: Rout[rc]=1, Zin, ALUControl = one-hot bit for op.
- T5:
  - Normal ops: Zlowout, Rin[ra]=1, done=1. Next state T0 if run=1, else IDLE.
  - mul/div: Zlowout, LOin. Go to T6.
- T6 (mul/div only): Zhighout, HIin, done=1. Next state T0 if run=1, else IDLE.
- Supported opcodes and ALUControl bit:
  - add 00011 → bit0, sub 00100 → bit1, and 00101 → bit2, or 00110 → bit3.
  - shr 00111 → bit4, shra 01000 → bit6, shl 01001 → bit5, ror 01010 → bit7, rol 01011 → bit8.
  - mul 01111 → bit9, div 10000 → bit10.
  - All other opcodes are illegal.
- Rout and Rin are each at most one-hot. Rin is nonzero only in T5 for normal ops.
- run is sampled only at instruction boundaries (IDLE, last execute state, illegal skip). Dropping run mid-instruction completes the instruction.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: CU_ILLEGAL_HALT_EN.
- Defined: an illegal opcode moves to IDLE after the T3 done pulse, regardless of run. The FSM holds there until reset, even if run=1.
- Undefined: illegal opcodes are skipped as described above and execution continues.

Decomposition:
- Package cu_pkg holds:
  - state encoding localparams (3-bit);
  - opcode localparams (OP_ADD … OP_DIV);
  - ALUControl bit-index localparams (ALU_ADD=0 … ALU_DIV=10);
  - field slice positions.
- One sub-module, reg_onehot_dec: 4-bit index plus enable in, 16-bit one-hot out. Instantiated twice: Rout (mux of rb/rc by state) and Rin (ra).

Test Plan:
- Reset mid-T4 (clr=0 pulse) → all outputs 0 immediately (asynchronous), state IDLE, and no Rin pulse follows.
- run=1, mem_rdy=1, Mdatain=32'h4A920000 (shl R5,R2,R4), R2=0x23, R4=3:
  - T3 Rout=16'h0004; T4 Rout=16'h0010 with ALUControl=12'h020; T5 Rin=16'h0020 and done=1;
  - R5=0x118.
- mem_rdy held 0 for 3 cycles in T1 → T1 strobes held for 4 cycles, then T2. mem_rdy held 0 for ≥15 cycles → mem_timeout=1, state IDLE.
- mul instruction op=01111 → T5 asserts LOin, T6 asserts HIin with done in T6, and Rin stays 0 throughout.
- op=11111 → illegal=1, done in T3, Rin never asserted. With CU_ILLEGAL_HALT_EN the FSM stays in IDLE while run=1.
- run dropped during T4 of an add → instruction completes (Rin pulse in T5), then IDLE with no further T0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the hardwired control sequencer: FSM states,
// R-format opcodes, ALUControl bit positions and IR field slices.
package cu_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  localparam int ALU_W    = 12;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_AND  = 2;
  localparam int ALU_OR   = 3;
  localparam int ALU_SHR  = 4;
  localparam int ALU_SHL  = 5;
  localparam int ALU_SHRA = 6;
  localparam int ALU_ROR  = 7;
  localparam int ALU_ROL  = 8;
  localparam int ALU_MUL  = 9;
  localparam int ALU_DIV  = 10;

  localparam int OP_HI = 31, OP_LO = 27;
  localparam int RA_HI = 26, RA_LO = 23;
  localparam int RB_HI = 22, RB_LO = 19;
  localparam int RC_HI = 18, RC_LO = 15;

  // Zero result doubles as the "unsupported opcode" indication.
  function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] op);
    logic [ALU_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r[ALU_ADD]  = 1'b1;
      OP_SUB:  r[ALU_SUB]  = 1'b1;
      OP_AND:  r[ALU_AND]  = 1'b1;
      OP_OR:   r[ALU_OR]   = 1'b1;
      OP_SHR:  r[ALU_SHR]  = 1'b1;
      OP_SHRA: r[ALU_SHRA] = 1'b1;
      OP_SHL:  r[ALU_SHL]  = 1'b1;
      OP_ROR:  r[ALU_ROR]  = 1'b1;
      OP_ROL:  r[ALU_ROL]  = 1'b1;
      OP_MUL:  r[ALU_MUL]  = 1'b1;
      OP_DIV:  r[ALU_DIV]  = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-bit register index to 16-bit one-hot select, gated by an enable.
module reg_onehot_dec (
  input  logic [3:0]  i_idx,
  input  logic        i_en,
  output logic [15:0] o_onehot
);
  assign o_onehot = i_en ? (16'h0001 << i_idx) : 16'h0000;
endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the bus datapath.
// CU_ILLEGAL_HALT_EN: an illegal opcode parks the FSM in IDLE until reset.
module alu_control_sequencer
  import cu_pkg::*;
#(
  parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        MDRRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [11:0] ALUControl,
  output logic        done,
  output logic        illegal,
  output logic        mem_timeout
);

`ifdef CU_ILLEGAL_HALT_EN
  localparam bit ILLEGAL_HALT = 1'b1;
`else
  localparam bit ILLEGAL_HALT = 1'b0;
`endif

  logic [2:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_illegal;
  logic             r_timeout;

  logic [4:0]       w_op;
  logic [3:0]       w_ra, w_rb, w_rc;
  logic [ALU_W-1:0] w_alu;
  logic             w_legal, w_muldiv;
  logic             w_unused;

  assign w_op     = ir[OP_HI:OP_LO];
  assign w_ra     = ir[RA_HI:RA_LO];
  assign w_rb     = ir[RB_HI:RB_LO];
  assign w_rc     = ir[RC_HI:RC_LO];
  assign w_alu    = alu_onehot(w_op);
  assign w_legal  = |w_alu;
  assign w_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_unused = ^ir[RC_LO-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (run && !(ILLEGAL_HALT && r_illegal)) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1: begin
          if (mem_rdy) begin
            r_state <= S_T2;
            r_cnt   <= 4'd0;
          end else if (r_cnt == MEM_WAIT_MAX - 4'd1) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_state   <= (run && !ILLEGAL_HALT) ? S_T0 : S_IDLE;
          end else begin
            r_state <= S_T4;
          end
        end
        S_T4:   r_state <= S_T5;
        S_T5:   r_state <= w_muldiv ? S_T6 : (run ? S_T0 : S_IDLE);
        S_T6:   r_state <= run ? S_T0 : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // T3 reads rb into Y; T4 reads rc onto the bus for the ALU.
  reg_onehot_dec u_rout_dec (
    .i_idx    ((r_state == S_T3) ? w_rb : w_rc),
    .i_en     ((r_state == S_T3) || (r_state == S_T4)),
    .o_onehot (Rout)
  );

  reg_onehot_dec u_rin_dec (
    .i_idx    (w_ra),
    .i_en     ((r_state == S_T5) && !w_muldiv),
    .o_onehot (Rin)
  );

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
    MDRRead = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; ALUControl = '0; done = 1'b0;
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; MDRRead = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin Yin = 1'b1; done = !w_legal; end
      S_T4: begin Zin = 1'b1; ALUControl = w_alu; end
      S_T5: begin Zlowout = 1'b1; LOin = w_muldiv; done = !w_muldiv; end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  assign illegal     = r_illegal;
  assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench: per-cycle expected control words are queued by the
// stimulus and popped by a monitor whenever any control output is active.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, PCin, MDRRead, MDRin, MDRout, IRin;
  logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, done, illegal, mem_timeout;
  logic [15:0] Rout, Rin;
  logic [11:0] ALUControl;

  alu_control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .MDRRead(MDRRead), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin),
    .ALUControl(ALUControl), .done(done), .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] s;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [11:0] alu;
    logic        done;
  } ov_t;

  typedef struct {
    ov_t   v;
    string nm;
  } exp_t;

  localparam logic [13:0] PCOUT = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800;
  localparam logic [13:0] PCIN  = 14'h0400, MDRRD = 14'h0200, MDRIN = 14'h0100;
  localparam logic [13:0] MDROUT = 14'h0080, IRIN = 14'h0040, YIN = 14'h0020;
  localparam logic [13:0] ZIN = 14'h0010, ZHI = 14'h0008, ZLO = 14'h0004;
  localparam logic [13:0] HIIN = 14'h0002, LOIN = 14'h0001;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   stall_req = 0;

  function automatic ov_t cur_ov();
    ov_t o;
    o.s    = {PCout, MARin, IncPC, PCin, MDRRead, MDRin, MDRout, IRin,
              Yin, Zin, Zhighout, Zlowout, HIin, LOin};
    o.rout = Rout;
    o.rin  = Rin;
    o.alu  = ALUControl;
    o.done = done;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic push(input string nm, input logic [13:0] s, input logic [15:0] ro,
                      input logic [15:0] ri, input logic [11:0] alu, input logic d);
    exp_t e;
    e.v  = '{s: s, rout: ro, rin: ri, alu: alu, done: d};
    e.nm = nm;
    q.push_back(e);
  endtask

  // kind: 0 normal, 1 mul/div, 2 illegal, 3 cut off after T4 by reset
  task automatic push_instr(input string nm, input int stalls, input logic [15:0] rb_oh,
                            input logic [15:0] rc_oh, input logic [15:0] rin_oh,
                            input logic [11:0] alu, input int kind);
    push({nm, " T0"}, PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 12'h0, 1'b0);
    for (int i = 0; i <= stalls; i++)
      push({nm, " T1"}, ZLO | PCIN | MDRRD | MDRIN, 16'h0, 16'h0, 12'h0, 1'b0);
    push({nm, " T2"}, MDROUT | IRIN, 16'h0, 16'h0, 12'h0, 1'b0);
    push({nm, " T3"}, YIN, rb_oh, 16'h0, 12'h0, kind == 2);
    if (kind == 2) return;
    push({nm, " T4"}, ZIN, rc_oh, 16'h0, alu, 1'b0);
    if (kind == 3) return;
    if (kind == 1) begin
      push({nm, " T5"}, ZLO | LOIN, 16'h0, 16'h0, 12'h0, 1'b0);
      push({nm, " T6"}, ZHI | HIIN, 16'h0, 16'h0, 12'h0, 1'b1);
    end else begin
      push({nm, " T5"}, ZLO, 16'h0, rin_oh, 12'h0, 1'b1);
    end
  endtask

  // which: 0 done, 1 T4 (ALU strobed), 2 mem_timeout. Returns on a negedge.
  task automatic wait_ev(input int which, input int maxc, input string nm);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < maxc && !hit; c++) begin
      @(negedge clk);
      case (which)
        0: hit = done;
        1: hit = Zin && (ALUControl != 12'h0);
        default: hit = mem_timeout;
      endcase
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: event not seen within %0d cycles", nm, maxc);
    end
  endtask

  task automatic monitor();
    ov_t  a;
    exp_t e;
    forever begin
      @(negedge clk);
      a = cur_ov();
      if (a != '0) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected: got %h want idle", a);
        end else begin
          e = q.pop_front();
          if (a !== e.v) begin
            fails++;
            $display("FAIL %s: got %h want %h", e.nm, a, e.v);
          end
        end
      end
    end
  endtask

  // Memory answers after stall_req cycles of a T1 read request.
  task automatic memory();
    int scnt;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!MDRRead) begin
        scnt    = 0;
        mem_rdy = 1'b0;
      end else begin
        mem_rdy = (scnt >= stall_req);
        scnt++;
      end
    end
  endtask

  localparam logic [31:0] IR_SHL  = 32'h4A920000;  // shl  R5,R2,R4
  localparam logic [31:0] IR_ADD  = 32'h18918000;  // add  R1,R2,R3
  localparam logic [31:0] IR_AND  = 32'h29A28000;  // and  R3,R4,R5
  localparam logic [31:0] IR_ROR  = 32'h500F8000;  // ror  R0,R1,R15
  localparam logic [31:0] IR_MUL  = 32'h7B3C0000;  // mul  R6,R7,R8
  localparam logic [31:0] IR_SHRA = 32'h41188000;  // shra R2,R3,R1
  localparam logic [31:0] IR_ILL  = 32'hF8000000;  // op 11111

  initial begin
    fork
      monitor();
      memory();
    join_none
    clr = 1'b0; run = 1'b0; ir = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 64'(cur_ov()), 64'h0);
    chk("reset flags", {62'h0, illegal, mem_timeout}, 64'h0);
    #1 clr = 1'b1;

    ir = IR_SHL; stall_req = 0;
    push_instr("shl", 0, 16'h0004, 16'h0010, 16'h0020, 12'h020, 0);
    run = 1'b1;
    wait_ev(0, 40, "shl done");
    run = 1'b0;
    repeat (3) @(negedge clk);

    ir = IR_ADD; stall_req = 3;
    push_instr("add stall", 3, 16'h0004, 16'h0008, 16'h0002, 12'h001, 0);
    run = 1'b1;
    wait_ev(0, 40, "add stall done");
    run = 1'b0; stall_req = 0;
    repeat (3) @(negedge clk);

    ir = IR_AND;
    push_instr("and", 0, 16'h0010, 16'h0020, 16'h0008, 12'h004, 0);
    push_instr("ror", 0, 16'h0002, 16'h8000, 16'h0001, 12'h080, 0);
    run = 1'b1;
    wait_ev(0, 40, "and done");
    @(posedge clk); #1 ir = IR_ROR;
    wait_ev(0, 40, "ror done");
    run = 1'b0;
    repeat (3) @(negedge clk);

    ir = IR_MUL;
    push_instr("mul", 0, 16'h0080, 16'h0100, 16'h0000, 12'h200, 1);
    run = 1'b1;
    wait_ev(0, 40, "mul done");
    run = 1'b0;
    repeat (3) @(negedge clk);

    ir = IR_ADD;
    push_instr("add rundrop", 0, 16'h0004, 16'h0008, 16'h0002, 12'h001, 0);
    run = 1'b1;
    wait_ev(1, 40, "add rundrop T4");
    run = 1'b0;
    wait_ev(0, 10, "add rundrop done");
    repeat (5) @(negedge clk);

    ir = IR_ILL;
    push_instr("illegal", 0, 16'h0001, 16'h0, 16'h0, 12'h0, 2);
`ifdef CU_ILLEGAL_HALT_EN
    run = 1'b1;
    wait_ev(0, 40, "illegal done");
    repeat (8) @(negedge clk);
    chk("illegal flag", {63'h0, illegal}, 64'h1);
    run = 1'b0;
`else
    push_instr("shra", 0, 16'h0008, 16'h0002, 16'h0004, 12'h040, 0);
    run = 1'b1;
    wait_ev(0, 40, "illegal done");
    @(posedge clk); #1 ir = IR_SHRA;
    chk("illegal flag", {63'h0, illegal}, 64'h1);
    wait_ev(0, 40, "shra done");
    run = 1'b0;
`endif
    repeat (3) @(negedge clk);

    ir = IR_ADD;
    push_instr("add reset", 0, 16'h0004, 16'h0008, 16'h0002, 12'h001, 3);
    run = 1'b1;
    wait_ev(1, 40, "add reset T4");
    #1 clr = 1'b0;
    #1 chk("async reset outputs", 64'(cur_ov()), 64'h0);
    chk("async reset flags", {62'h0, illegal, mem_timeout}, 64'h0);
    run = 1'b0;
    @(negedge clk); #1 clr = 1'b1;
    repeat (6) @(negedge clk);

    ir = IR_ADD; stall_req = 100;
    push("tmo T0", PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 12'h0, 1'b0);
    for (int i = 0; i < 15; i++)
      push("tmo T1", ZLO | PCIN | MDRRD | MDRIN, 16'h0, 16'h0, 12'h0, 1'b0);
    run = 1'b1;
    wait_ev(2, 60, "mem timeout");
    run = 1'b0; stall_req = 0;
    chk("timeout flags", {62'h0, illegal, mem_timeout}, 64'h1);
    repeat (4) @(negedge clk);
    #1 clr = 1'b0;
    #1 chk("timeout cleared", {63'h0, mem_timeout}, 64'h0);
    #1 clr = 1'b1;
    repeat (3) @(negedge clk);

    chk("scoreboard drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
